mem_access_unit: RTL and testbench

- Bus-side stage directly upstream of the multi-cycle datapath.
- Owns the instruction register (IR) and memory data register (MDR).
- Runs the readM/inputReady and writeM/ackOutput handshakes with external memory for the fetch, load and store steps requested by the control FSM.
- Feeds IR fields and MDR to the datapath and reports completion, timeout and a retired-fetch count.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/bus_timeout_counter.sv | 27 ++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the memory access unit: FSM states, access
// kinds and the request bundle seen in IDLE.
package mem_access_unit_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    MAU_IDLE  = 2'd0,
    MAU_READ  = 2'd1,
    MAU_WRITE = 2'd2,
    MAU_DONE  = 2'd3
  } mau_state_e;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_kind_e;

  typedef struct packed {
    logic fetch;
    logic load;
    logic store;
  } acc_req_t;

  // More than one simultaneous request is an illegal command from control.
  function automatic logic req_multi(acc_req_t r);
    return $countones(r) > 1;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on a bus response; expired is high while the
// count sits at TIMEOUT_CYCLES-1 (the last cycle a response is still accepted).
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != LAST))
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Bus-side access stage: owns IR/MDR and runs the read/write handshakes for
// fetch, load and store steps, with timeout and a retired-fetch counter.
module mem_access_unit #(
  parameter int WORD_SIZE      = mem_access_unit_pkg::WORD_SIZE,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic                 load_req,
  input  logic                 store_req,
  input  logic [WORD_SIZE-1:0] inst_addr,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] store_data,
  input  logic [WORD_SIZE-1:0] mem_data_in,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] mem_data_out,
  output logic [WORD_SIZE-1:0] ir,
  output logic [WORD_SIZE-1:0] mdr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     fetch_count
);
  import mem_access_unit_pkg::*;

  mau_state_e           state, state_nx;
  acc_kind_e            kind, kind_nx;
  acc_req_t             req;
  logic [WORD_SIZE-1:0] address_nx, wdata_nx, ir_nx, mdr_nx;
  logic [CNT_W-1:0]     count_nx;
  logic                 err_nx, tmo_clr, tmo_en, tmo_expired;

  assign req.fetch = fetch_req;
  assign req.load  = load_req;
  assign req.store = store_req;

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nx   = state;
    kind_nx    = kind;
    address_nx = address;
    wdata_nx   = mem_data_out;
    ir_nx      = ir;
    mdr_nx     = mdr;
    count_nx   = fetch_count;
    err_nx     = err;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;

    case (state)
      MAU_IDLE: begin
        // Holding the counter clear here guarantees a fresh count on entry.
        tmo_clr = 1'b1;
        if (req_multi(req)) begin
          state_nx = MAU_DONE;
          err_nx   = 1'b1;
        end else if (req.fetch) begin
          kind_nx    = ACC_FETCH;
          address_nx = inst_addr;
          state_nx   = MAU_READ;
        end else if (req.load) begin
          kind_nx    = ACC_LOAD;
          address_nx = data_addr;
          state_nx   = MAU_READ;
        end else if (req.store) begin
          kind_nx    = ACC_STORE;
          address_nx = data_addr;
          wdata_nx   = store_data;
          state_nx   = MAU_WRITE;
        end
      end

      MAU_READ: begin
        if (inputReady) begin
          if (kind == ACC_FETCH) begin
            ir_nx    = mem_data_in;
            count_nx = fetch_count + 1'b1;
          end else begin
            mdr_nx = mem_data_in;
          end
          err_nx   = 1'b0;
          state_nx = MAU_DONE;
        end else if (tmo_expired) begin
          err_nx   = 1'b1;
          state_nx = MAU_DONE;
        end else begin
          tmo_en = 1'b1;
        end
      end

      MAU_WRITE: begin
        if (ackOutput) begin
          err_nx   = 1'b0;
          state_nx = MAU_DONE;
        end else if (tmo_expired) begin
          err_nx   = 1'b1;
          state_nx = MAU_DONE;
        end else begin
          tmo_en = 1'b1;
        end
      end

      MAU_DONE: begin
        tmo_clr  = 1'b1;
        state_nx = MAU_IDLE;
      end

      default: state_nx = MAU_IDLE;
    endcase
  end

  // Strobes and status are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= MAU_IDLE;
      kind         <= ACC_FETCH;
      readM        <= 1'b0;
      writeM       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      address      <= '0;
      mem_data_out <= '0;
      ir           <= '0;
      mdr          <= '0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nx;
      kind         <= kind_nx;
      readM        <= (state_nx == MAU_READ);
      writeM       <= (state_nx == MAU_WRITE);
      busy         <= (state_nx != MAU_IDLE);
      done         <= (state_nx == MAU_DONE);
      err          <= err_nx;
      address      <= address_nx;
      mem_data_out <= wdata_nx;
      ir           <= ir_nx;
      mdr          <= mdr_nx;
      fetch_count  <= count_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level
// model of IR, MDR, fetch count, strobe length and error status.
module tb_mem_access_unit;

  localparam int WS    = 16;
  localparam int TMO   = 4;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, load_req, store_req;
  logic [WS-1:0] inst_addr, data_addr, store_data, mem_data_in;
  logic          inputReady, ackOutput;
  logic          readM, writeM, busy, done, err;
  logic [WS-1:0] address, mem_data_out, ir, mdr;
  logic [CNT_W-1:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [WS-1:0] m_ir, m_mdr;
  int            m_cnt;

  mem_access_unit #(.WORD_SIZE(WS), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .inst_addr(inst_addr), .data_addr(data_addr), .store_data(store_data),
    .mem_data_in(mem_data_in), .inputReady(inputReady), .ackOutput(ackOutput),
    .readM(readM), .writeM(writeM), .address(address), .mem_data_out(mem_data_out),
    .ir(ir), .mdr(mdr), .busy(busy), .done(done), .err(err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outcome of one access from the request/response rules alone.
  task automatic model_access(input logic [2:0] req, input logic [WS-1:0] rdata,
                              input int resp_at, output int exp_strobes, output bit exp_err);
    bit hit;
    if ($countones(req) != 1) begin
      exp_strobes = 0;
      exp_err     = 1'b1;
      return;
    end
    hit         = (resp_at >= 1) && (resp_at <= TMO);
    exp_strobes = hit ? resp_at : TMO;
    exp_err     = !hit;
    if (hit && req[0]) begin
      m_ir  = rdata;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    if (hit && req[1]) m_mdr = rdata;
  endtask

  // Drives one request ({store,load,fetch}) and acts as memory; response in
  // strobe cycle resp_at (0 = never). Reports what was observed on the bus.
  task automatic run_access(input logic [2:0] req, input logic [WS-1:0] addr,
                            input logic [WS-1:0] wdata, input logic [WS-1:0] rdata,
                            input int resp_at, input bit interfere,
                            output int strobes, output bit stable, output bit done_ok,
                            output bit err_seen, output bit idle_ok);
    @(negedge clk);
    fetch_req  = req[0];
    load_req   = req[1];
    store_req  = req[2];
    inst_addr  = req[0] ? addr : WS'($urandom);
    data_addr  = req[0] ? WS'($urandom) : addr;
    store_data = wdata;
    @(negedge clk);
    fetch_req  = 1'b0;
    load_req   = 1'b0;
    store_req  = 1'b0;
    inst_addr  = WS'($urandom);
    data_addr  = WS'($urandom);
    store_data = WS'($urandom);
    strobes = 0;
    stable  = 1'b1;
    while ((readM || writeM) && strobes < 40) begin
      strobes++;
      if (address !== addr || done !== 1'b0 || busy !== 1'b1 || writeM !== req[2] ||
          readM !== !req[2] || (req[2] && mem_data_out !== wdata))
        stable = 1'b0;
      mem_data_in = (strobes == resp_at) ? rdata : WS'($urandom);
      inputReady  = (!req[2] && strobes == resp_at) || (interfere && req[2]);
      ackOutput   = (req[2] && strobes == resp_at) || (interfere && !req[2]);
      load_req    = interfere;
      @(negedge clk);
    end
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    load_req   = 1'b0;
    done_ok  = (done === 1'b1) && (readM === 1'b0) && (writeM === 1'b0) && (busy === 1'b1);
    err_seen = err;
    @(negedge clk);
    idle_ok  = (done === 1'b0) && (busy === 1'b0) && (readM === 1'b0) &&
               (writeM === 1'b0) && (err === err_seen);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    if ({readM, writeM, done, err, busy} !== 5'b0) begin
      $display("FAIL reset_ctrl: got %b expected 00000", {readM, writeM, done, err, busy}); n_fail++;
    end
    n_checks++;
    if ({address, mem_data_out} !== '0) begin
      $display("FAIL reset_bus: got %h expected 0", {address, mem_data_out}); n_fail++;
    end
    n_checks++;
    if ({ir, mdr, fetch_count} !== '0) begin
      $display("FAIL reset_regs: got %h expected 0", {ir, mdr, fetch_count}); n_fail++;
    end
    n_checks++;
    reset = 1'b0;
    m_ir = '0; m_mdr = '0; m_cnt = 0;
  endtask

  task automatic test_fetch();
    int s, es; bit st, dk, e, ee, id;
    run_access(3'b001, 16'h0010, 16'h0, 16'h6A05, 1, 1'b0, s, st, dk, e, id);
    model_access(3'b001, 16'h6A05, 1, es, ee);
    if (s !== es || !st || !dk) begin
      $display("FAIL fetch_bus: strobes %0d stable %b done %b expected %0d 1 1", s, st, dk, es); n_fail++;
    end
    n_checks++;
    if (ir !== m_ir || fetch_count !== CNT_W'(m_cnt) || e !== ee) begin
      $display("FAIL fetch_result: ir %h cnt %0d err %b expected %h %0d %b", ir, fetch_count, e, m_ir, m_cnt, ee); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_load_wait();
    int s, es; bit st, dk, e, ee, id;
    run_access(3'b010, 16'h0123, 16'h0, 16'hBEEF, 4, 1'b0, s, st, dk, e, id);
    model_access(3'b010, 16'hBEEF, 4, es, ee);
    if (s !== es || !st || !dk || !id) begin
      $display("FAIL load_bus: strobes %0d stable %b done %b idle %b expected %0d 1 1 1", s, st, dk, id, es); n_fail++;
    end
    n_checks++;
    if (mdr !== m_mdr || ir !== m_ir || e !== ee) begin
      $display("FAIL load_result: mdr %h ir %h err %b expected %h %h %b", mdr, ir, e, m_mdr, m_ir, ee); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_store();
    int s, es; bit st, dk, e, ee, id;
    run_access(3'b100, 16'h0040, 16'h1234, 16'hDEAD, 3, 1'b0, s, st, dk, e, id);
    model_access(3'b100, 16'hDEAD, 3, es, ee);
    if (s !== es || !st || !dk || !id) begin
      $display("FAIL store_bus: strobes %0d stable %b done %b idle %b expected %0d 1 1 1", s, st, dk, id, es); n_fail++;
    end
    n_checks++;
    if (mdr !== m_mdr || ir !== m_ir || e !== ee) begin
      $display("FAIL store_result: mdr %h ir %h err %b expected %h %h %b", mdr, ir, e, m_mdr, m_ir, ee); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_timeout();
    int s, es; bit st, dk, e, ee, id;
    run_access(3'b001, 16'h0200, 16'h0, 16'h7777, 0, 1'b0, s, st, dk, e, id);
    model_access(3'b001, 16'h7777, 0, es, ee);
    if (s !== es || !dk || e !== ee || ir !== m_ir || fetch_count !== CNT_W'(m_cnt)) begin
      $display("FAIL timeout_abort: strobes %0d err %b ir %h cnt %0d expected %0d %b %h %0d", s, e, ir, fetch_count, es, ee, m_ir, m_cnt); n_fail++;
    end
    n_checks++;
    run_access(3'b001, 16'h0202, 16'h0, 16'h5A5A, TMO, 1'b0, s, st, dk, e, id);
    model_access(3'b001, 16'h5A5A, TMO, es, ee);
    if (s !== es || !dk || e !== ee || ir !== m_ir || fetch_count !== CNT_W'(m_cnt)) begin
      $display("FAIL timeout_lastcycle: strobes %0d err %b ir %h cnt %0d expected %0d %b %h %0d", s, e, ir, fetch_count, es, ee, m_ir, m_cnt); n_fail++;
    end
    n_checks++;
    run_access(3'b100, 16'h0300, 16'h4321, 16'h0, 0, 1'b0, s, st, dk, e, id);
    model_access(3'b100, 16'h0, 0, es, ee);
    if (s !== es || !st || e !== ee) begin
      $display("FAIL timeout_store: strobes %0d stable %b err %b expected %0d 1 %b", s, st, e, es, ee); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_illegal_and_busy();
    int s, es; bit st, dk, e, ee, id;
    logic [2:0] bad [3] = '{3'b101, 3'b011, 3'b111};
    foreach (bad[i]) begin
      run_access(bad[i], 16'h0400, 16'h1111, 16'h2222, 1, 1'b0, s, st, dk, e, id);
      model_access(bad[i], 16'h2222, 1, es, ee);
      if (s !== es || !dk || e !== ee || !id || ir !== m_ir || mdr !== m_mdr || fetch_count !== CNT_W'(m_cnt)) begin
        $display("FAIL illegal_%b: strobes %0d done %b err %b idle %b ir %h mdr %h expected %0d 1 %b 1 %h %h", bad[i], s, dk, e, id, ir, mdr, es, ee, m_ir, m_mdr); n_fail++;
      end
      n_checks++;
    end
    // load_req and a stray ackOutput during a fetch must both be ignored
    run_access(3'b001, 16'h0500, 16'h0, 16'h0F0F, 2, 1'b1, s, st, dk, e, id);
    model_access(3'b001, 16'h0F0F, 2, es, ee);
    if (s !== es || !st || !dk || !id || mdr !== m_mdr || ir !== m_ir || e !== ee) begin
      $display("FAIL busy_ignore: strobes %0d stable %b idle %b mdr %h ir %h expected %0d 1 1 %h %h", s, st, id, mdr, ir, es, m_mdr, m_ir); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    store_req = 1'b1; data_addr = 16'h0600; store_data = 16'hCAFE;
    @(negedge clk);
    store_req = 1'b0;
    @(negedge clk);
    if (writeM !== 1'b1 || address !== 16'h0600) begin
      $display("FAIL midwrite_pre: writeM %b addr %h expected 1 0600", writeM, address); n_fail++;
    end
    n_checks++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if ({readM, writeM, done, err, busy} !== 5'b0 || {address, mem_data_out, ir, mdr, fetch_count} !== '0) begin
      $display("FAIL midwrite_reset: ctrl %b regs %h expected all 0", {readM, writeM, done, err, busy}, {address, mem_data_out, ir, mdr, fetch_count}); n_fail++;
    end
    n_checks++;
    m_ir = '0; m_mdr = '0; m_cnt = 0;
  endtask

  task automatic test_wrap();
    int s, es; bit st, dk, e, ee, id;
    for (int k = 1; k <= (1 << CNT_W); k++) begin
      run_access(3'b001, WS'(k), 16'h0, WS'(16'h9000 + k), 1, 1'b0, s, st, dk, e, id);
      model_access(3'b001, WS'(16'h9000 + k), 1, es, ee);
      if (k >= (1 << CNT_W) - 1) begin
        if (fetch_count !== CNT_W'(m_cnt) || ir !== m_ir) begin
          $display("FAIL wrap_%0d: cnt %0d ir %h expected %0d %h", k, fetch_count, ir, m_cnt, m_ir); n_fail++;
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_random();
    int s, es, resp; bit st, dk, e, ee, id;
    logic [2:0] req;
    logic [WS-1:0] a, wd, rd;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: req = 3'b001;
        1: req = 3'b010;
        2: req = 3'b100;
        default: req = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b011;
      endcase
      a = WS'($urandom); wd = WS'($urandom); rd = WS'($urandom);
      resp = $urandom_range(0, TMO + 1);
      run_access(req, a, wd, rd, resp, 1'b0, s, st, dk, e, id);
      model_access(req, rd, resp, es, ee);
      if (s !== es || !st || !dk || !id) begin
        $display("FAIL rand%0d_bus: req %b strobes %0d stable %b done %b idle %b expected %0d 1 1 1", it, req, s, st, dk, id, es); n_fail++;
      end
      n_checks++;
      if (e !== ee) begin
        $display("FAIL rand%0d_err: got %b expected %b", it, e, ee); n_fail++;
      end
      n_checks++;
      if (ir !== m_ir || mdr !== m_mdr || fetch_count !== CNT_W'(m_cnt)) begin
        $display("FAIL rand%0d_regs: ir %h mdr %h cnt %0d expected %h %h %0d", it, ir, mdr, fetch_count, m_ir, m_mdr, m_cnt); n_fail++;
      end
      n_checks++;
    end
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
    inst_addr = '0; data_addr = '0; store_data = '0; mem_data_in = '0;
    inputReady = 1'b0; ackOutput = 1'b0;
    test_reset();
    test_fetch();
    test_load_wait();
    test_store();
    test_timeout();
    test_illegal_and_busy();
    test_reset_mid_write();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
